// File: rtl/multiple_instructions.sv
// Single-cycle RV32I integer core for OP and OP-IMM instructions.
// Program words are loaded hierarchically into program_memory. Each rising
// clock edge executes the word at pc, writes rd, and advances pc by 4.
// The fetch index wraps at PROG_DEPTH words.

// 32 x 32-bit register file, memory[n] = xn.
// Reads are combinational. The write occurs at the clock edge.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);
  logic [31:0] memory [32];

  // Clear every register on reset; otherwise write rd unless it is x0.
  // NOTE: this array is reset on purpose because it is architectural state.
  // program_memory is deliberately left without a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) memory[i] <= '0;
    end else if (wr_en && rd_addr != 5'd0) begin
      memory[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : memory[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : memory[rs2_addr];
endmodule

// Decode and execute one instruction and produce the write-back for rd.
module exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction
);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm;
  logic [4:0]  shamt_imm, shamt_reg;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] sra_imm, sra_reg;
  logic        lt_imm, ltu_imm, lt_reg, ltu_reg;
  logic        wr_en;
  logic [31:0] result;

  assign opcode    = instruction[6:0];
  assign rd        = instruction[11:7];
  assign funct3    = instruction[14:12];
  assign rs1       = instruction[19:15];
  assign rs2       = instruction[24:20];
  assign alt       = instruction[30];
  assign imm       = {{20{instruction[31]}}, instruction[31:20]};
  assign shamt_imm = instruction[24:20];
  assign shamt_reg = rs2_data[4:0];

  // Signed operations are kept as separate assigns so that signedness
  // is not lost when these values are selected in the mux below.
  assign sra_imm = $signed(rs1_data) >>> shamt_imm;
  assign sra_reg = $signed(rs1_data) >>> shamt_reg;
  assign lt_imm  = $signed(rs1_data) < $signed(imm);
  assign ltu_imm = rs1_data < imm;
  assign lt_reg  = $signed(rs1_data) < $signed(rs2_data);
  assign ltu_reg = rs1_data < rs2_data;

  reg_file reg_mem (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (wr_en),
    .rd_addr  (rd),
    .rd_data  (result)
  );

  // ALU: select the result for OP / OP-IMM. Any other opcode is a no-op.
  // NOTE: wr_en and result get defaults first, so no path can infer a latch.
  always_comb begin
    wr_en  = 1'b0;
    result = '0;
    case (opcode)
      OPC_OP_IMM: begin
        wr_en = 1'b1;
        case (funct3)
          3'b000:  result = rs1_data + imm;
          3'b010:  result = {31'b0, lt_imm};
          3'b011:  result = {31'b0, ltu_imm};
          3'b100:  result = rs1_data ^ imm;
          3'b110:  result = rs1_data | imm;
          3'b111:  result = rs1_data & imm;
          3'b001:  result = rs1_data << shamt_imm;
          default: result = alt ? sra_imm : (rs1_data >> shamt_imm);
        endcase
      end
      OPC_OP: begin
        wr_en = 1'b1;
        case (funct3)
          3'b000:  result = alt ? (rs1_data - rs2_data) : (rs1_data + rs2_data);
          3'b001:  result = rs1_data << shamt_reg;
          3'b010:  result = {31'b0, lt_reg};
          3'b011:  result = {31'b0, ltu_reg};
          3'b100:  result = rs1_data ^ rs2_data;
          3'b101:  result = alt ? sra_reg : (rs1_data >> shamt_reg);
          3'b110:  result = rs1_data | rs2_data;
          default: result = rs1_data & rs2_data;
        endcase
      end
      default: begin
        wr_en  = 1'b0;
        result = '0;
      end
    endcase
  end
endmodule

// Top level: program memory, pc, and combinational fetch.
module multiple_instructions #(
  parameter int PROG_DEPTH = 64
) (
  input  logic clk,
  input  logic reset
);
  localparam int AW = $clog2(PROG_DEPTH);

  logic [31:0]   program_memory [PROG_DEPTH];
  logic [31:0]   pc;
  logic [31:0]   instruction;
  logic [AW-1:0] pc_index, pc_index_next;
  logic          unused_pc;

  assign pc_index      = pc[AW+1:2];
  assign pc_index_next = pc_index + AW'(1);
  assign instruction   = program_memory[pc_index];
  assign unused_pc     = ^{pc[31:AW+2], pc[1:0]};

  // Advance pc by one word, wrapping modulo 4*PROG_DEPTH. Reset wins.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= {{(30-AW){1'b0}}, pc_index_next, 2'b00};
  end

  exec_stage single_instr (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction)
  );
endmodule

// File: tb/tb_multiple_instructions.sv
// Bench for multiple_instructions: directed programs plus a random program.
// The random program is checked against a mnemonic-level reference model.
module tb_multiple_instructions;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  multiple_instructions #(.PROG_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  typedef enum {M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI,
                M_SRAI, M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA,
                M_OR, M_AND, M_NOP} mn_t;

  typedef struct {
    mn_t         mn;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] raw;
  } instr_t;

  logic [31:0] prog [DEPTH];
  instr_t      prog_t [DEPTH];
  logic [31:0] mregs [32];
  int unsigned mpc;

  function automatic instr_t mk(mn_t mn, int rd, int rs1, int rs2, int imm);
    instr_t t;
    t.mn = mn; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
    t.imm = 12'(imm); t.raw = '0;
    return t;
  endfunction

  function automatic logic [31:0] enc(instr_t t);
    logic [2:0] f3;
    logic       alt;
    logic       is_imm;
    f3 = 3'b000; alt = 1'b0; is_imm = 1'b1;
    case (t.mn)
      M_ADDI:  f3 = 3'b000;
      M_SLTI:  f3 = 3'b010;
      M_SLTIU: f3 = 3'b011;
      M_XORI:  f3 = 3'b100;
      M_ORI:   f3 = 3'b110;
      M_ANDI:  f3 = 3'b111;
      M_SLLI:  f3 = 3'b001;
      M_SRLI:  f3 = 3'b101;
      M_SRAI:  begin f3 = 3'b101; alt = 1'b1; end
      M_ADD:   begin f3 = 3'b000; is_imm = 1'b0; end
      M_SUB:   begin f3 = 3'b000; is_imm = 1'b0; alt = 1'b1; end
      M_SLL:   begin f3 = 3'b001; is_imm = 1'b0; end
      M_SLT:   begin f3 = 3'b010; is_imm = 1'b0; end
      M_SLTU:  begin f3 = 3'b011; is_imm = 1'b0; end
      M_XOR:   begin f3 = 3'b100; is_imm = 1'b0; end
      M_SRL:   begin f3 = 3'b101; is_imm = 1'b0; end
      M_SRA:   begin f3 = 3'b101; is_imm = 1'b0; alt = 1'b1; end
      M_OR:    begin f3 = 3'b110; is_imm = 1'b0; end
      M_AND:   begin f3 = 3'b111; is_imm = 1'b0; end
      default: return t.raw;
    endcase
    if (!is_imm)
      return {1'b0, alt, 5'b0, t.rs2, t.rs1, f3, t.rd, 7'b0110011};
    if (f3 == 3'b001 || f3 == 3'b101)
      return {1'b0, alt, 5'b0, t.imm[4:0], t.rs1, f3, t.rd, 7'b0010011};
    return {t.imm, t.rs1, f3, t.rd, 7'b0010011};
  endfunction

  // Arithmetic right shift built from a logical shift and a sign fill.
  function automatic logic [31:0] sra32(logic [31:0] a, int s);
    logic [31:0] r;
    r = a >> s;
    if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
    return r;
  endfunction

  function automatic logic [31:0] model(instr_t t, logic [31:0] a, logic [31:0] b);
    logic [31:0] si;
    longint      sa, sb, ss;
    int          shi, shr;
    si  = {{20{t.imm[11]}}, t.imm};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ss  = longint'($signed(si));
    shi = int'(t.imm[4:0]);
    shr = int'(b % 32);
    case (t.mn)
      M_ADDI:  return a + si;
      M_SLTI:  return (sa < ss) ? 32'd1 : 32'd0;
      M_SLTIU: return (a < si) ? 32'd1 : 32'd0;
      M_XORI:  return a ^ si;
      M_ORI:   return a | si;
      M_ANDI:  return a & si;
      M_SLLI:  return a << shi;
      M_SRLI:  return a >> shi;
      M_SRAI:  return sra32(a, shi);
      M_ADD:   return a + b;
      M_SUB:   return a - b;
      M_SLL:   return a << shr;
      M_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      M_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      M_XOR:   return a ^ b;
      M_SRL:   return a >> shr;
      M_SRA:   return sra32(a, shr);
      M_OR:    return a | b;
      M_AND:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] xr(int n);
    return dut.single_instr.reg_mem.memory[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_edge();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'd0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) dut.program_memory[i] = prog[i];
  endtask

  logic [31:0] exp_x5 [5];
  logic [31:0] nop_opc [4];
  logic [31:0] res;
  logic [31:0] w;
  instr_t      t;

  initial begin
    // Reset state
    clear_prog();
    load_prog();
    #2;
    reset_edge();
    check("reset_pc", dut.pc, 32'd0);
    check("reset_x5", xr(5), 32'd0);
    check("reset_x0", xr(0), 32'd0);

    // ADDI/ANDI/ORI sequence on x5, including the rd-as-source case
    clear_prog();
    prog[0] = enc(mk(M_ADDI, 5, 0, 0, 120));
    prog[1] = enc(mk(M_ADDI, 5, 0, 0, 200));
    prog[2] = enc(mk(M_ADDI, 5, 5, 0, 2000));
    prog[3] = enc(mk(M_ANDI, 5, 0, 0, 12'hFFF));
    prog[4] = enc(mk(M_ORI,  5, 0, 0, 12'h00A));
    load_prog();
    reset_edge();
    exp_x5[0] = 32'd120; exp_x5[1] = 32'd200; exp_x5[2] = 32'd2200;
    exp_x5[3] = 32'd0;   exp_x5[4] = 32'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("seq1_x5_%0d", i), xr(5), exp_x5[i]);
      check($sformatf("seq1_pc_%0d", i), dut.pc, 32'(4 * (i + 1)));
    end

    // Register-register ADD
    clear_prog();
    prog[0] = enc(mk(M_ADDI, 29, 0, 0, 2));
    prog[1] = enc(mk(M_ADDI, 31, 0, 0, 5));
    prog[2] = enc(mk(M_ADD, 5, 31, 29, 0));
    load_prog();
    reset_edge();
    for (int i = 0; i < 3; i++) tick();
    check("add_x29", xr(29), 32'd2);
    check("add_x31", xr(31), 32'd5);
    check("add_x5",  xr(5),  32'd7);

    // Signed/unsigned compares, arithmetic shift, and x0 write discard
    clear_prog();
    prog[0] = enc(mk(M_ADDI,  1, 0, 0, 12'hFFF));
    prog[1] = enc(mk(M_SLTIU, 2, 1, 0, 1));
    prog[2] = enc(mk(M_SLT,   3, 1, 0, 0));
    prog[3] = enc(mk(M_SRAI,  4, 1, 0, 4));
    prog[4] = enc(mk(M_ADDI,  0, 0, 0, 5));
    prog[5] = enc(mk(M_ADD,   6, 0, 0, 0));
    load_prog();
    reset_edge();
    for (int i = 0; i < 6; i++) tick();
    check("cmp_x1", xr(1), 32'hFFFF_FFFF);
    check("cmp_x2", xr(2), 32'd0);
    check("cmp_x3", xr(3), 32'd1);
    check("cmp_x4", xr(4), 32'hFFFF_FFFF);
    check("x0_x0",  xr(0), 32'd0);
    check("x0_x6",  xr(6), 32'd0);

    // All-zero words are no-ops, and pc wraps after DEPTH edges
    clear_prog();
    load_prog();
    reset_edge();
    tick();
    check("nop_pc", dut.pc, 32'd4);
    for (int r = 0; r < 32; r++) check($sformatf("nop_x%0d", r), xr(r), 32'd0);
    for (int i = 1; i < DEPTH; i++) tick();
    check("wrap_pc", dut.pc, 32'd0);

    // Mid-program reset: no change before the edge, cleared at it, restart at word 0
    clear_prog();
    prog[0] = enc(mk(M_ADDI, 1, 0, 0, 7));
    prog[1] = enc(mk(M_ADDI, 2, 0, 0, 9));
    prog[2] = enc(mk(M_ADDI, 3, 0, 0, 11));
    load_prog();
    reset_edge();
    tick();
    tick();
    reset = 1'b1;
    #2;
    check("rst_hold_pc", dut.pc, 32'd8);
    check("rst_hold_x1", xr(1), 32'd7);
    tick();
    reset = 1'b0;
    check("rst_pc", dut.pc, 32'd0);
    check("rst_x1", xr(1), 32'd0);
    check("rst_x2", xr(2), 32'd0);
    check("rst_x3", xr(3), 32'd0);
    tick();
    check("restart_pc", dut.pc, 32'd4);
    check("restart_x1", xr(1), 32'd7);
    check("restart_x2", xr(2), 32'd0);

    // Random program checked against the reference model, running past the wrap
    nop_opc[0] = 32'h00; nop_opc[1] = 32'h03; nop_opc[2] = 32'h63; nop_opc[3] = 32'h37;
    for (int i = 0; i < DEPTH; i++) begin
      t = mk(mn_t'($urandom_range(0, 19)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 4095)));
      if ($urandom_range(0, 2) == 0 || i < 6) begin
        t.mn = M_ADDI;
        if (t.rd == 5'd0) t.rd = 5'd1;
      end
      if (t.mn == M_NOP) begin
        w = $urandom();
        w[6:0] = nop_opc[$urandom_range(0, 3)][6:0];
        t.raw = w;
      end
      prog_t[i] = t;
      prog[i] = enc(t);
    end
    load_prog();
    reset_edge();
    for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
    mpc = 0;
    for (int s = 0; s < DEPTH + 16; s++) begin
      t = prog_t[mpc / 4];
      res = model(t, mregs[t.rs1], mregs[t.rs2]);
      if (t.mn != M_NOP && t.rd != 5'd0) mregs[t.rd] = res;
      mpc = (mpc + 4) % (4 * DEPTH);
      tick();
      check($sformatf("rnd_pc_%0d", s), dut.pc, 32'(mpc));
      check($sformatf("rnd_%s_x%0d_%0d", t.mn.name(), t.rd, s), xr(int'(t.rd)), mregs[t.rd]);
    end
    for (int r = 0; r < 32; r++) check($sformatf("rnd_final_x%0d", r), xr(r), mregs[r]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
